// File: rtl/timer_pkg.sv
// timer_pkg
// Shared constants for interval_timer: register word indices, CTRL bit
// positions and the STATUS PEND bit position.
package timer_pkg;

  // Register word indices (bus addr field)
  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RELOAD_BIT = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int CTRL_PRESC_LSB  = 8;
  localparam int CTRL_PRESC_MSB  = 15;

  // STATUS bit positions
  localparam int STATUS_PEND_BIT = 0;

endpackage

// File: rtl/interval_timer_if.sv
// interval_timer_if
// Register-bus bundle between the memory controller (master) and the
// timer (slave).
//   sel     : one-cycle access strobe
//   wr      : 1 = write, 0 = read (qualified by sel)
//   addr    : register word index
//   wr_data : write data
//   rd_data : registered read data, valid the cycle after a read strobe
interface interval_timer_if #(
  parameter int WIDTH = 32
);
  logic             sel;
  logic             wr;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  modport master (output sel, output wr, output addr, output wr_data, input rd_data);
  modport slave  (input sel, input wr, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the enabled clock by prescale+1 to produce a one-cycle tick.
// Only instantiated when TIMER_PRESCALE_EN is defined.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : counter runs only while the timer is enabled
//   clr        : restart the divide sequence (enable edge)
//   prescale   : divide value minus one
//   tick       : one-cycle pulse every prescale+1 enabled cycles
module timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  // >= rather than == so lowering PRESCALE mid-count cannot strand the
  // counter above the new terminal value.
  assign tick = en & (cnt_q >= prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/interval_timer.sv
// interval_timer
// Memory-mapped down-counting timer with one-shot/periodic modes, a sticky
// pending flag and an interrupt level (alert = PEND & IE).
// Optional feature macro: TIMER_PRESCALE_EN (adds CTRL[15:8] PRESCALE and
// the timer_prescaler tick divider).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : register bus slave (sel/wr/addr/wr_data/rd_data)
//   alert_ack  : one-cycle interrupt acknowledge, clears PEND
//   alert      : interrupt request, registered-only path
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  interval_timer_if.slave    bus,
  input  logic               alert_ack,
  output logic               alert
);

  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             en_q, en_d;
  logic             reload_q, reload_d;
  logic             ie_q, ie_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic             ld_wr, ctrl_wr, st_wr, rd_en;
  logic             en_edge, tick, expire;
  logic [WIDTH-1:0] ctrl_view;

  assign ld_wr   = bus.sel & bus.wr & (bus.addr == REG_LOAD);
  assign ctrl_wr = bus.sel & bus.wr & (bus.addr == REG_CTRL);
  assign st_wr   = bus.sel & bus.wr & (bus.addr == REG_STATUS);
  assign rd_en   = bus.sel & ~bus.wr;

  assign en_edge = ctrl_wr & bus.wr_data[CTRL_EN_BIT] & ~en_q;
  assign expire  = tick & (count_q == WIDTH'(1));

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (ctrl_wr) presc_d = bus.wr_data[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_q),
    .clr      (en_edge),
    .prescale (presc_q),
    .tick     (tick)
  );

  always_comb begin
    ctrl_view = '0;
    ctrl_view[CTRL_EN_BIT]     = en_q;
    ctrl_view[CTRL_RELOAD_BIT] = reload_q;
    ctrl_view[CTRL_IE_BIT]     = ie_q;
    ctrl_view[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_q;
  end
`else
  assign tick = en_q;

  always_comb begin
    ctrl_view = '0;
    ctrl_view[CTRL_EN_BIT]     = en_q;
    ctrl_view[CTRL_RELOAD_BIT] = reload_q;
    ctrl_view[CTRL_IE_BIT]     = ie_q;
  end
`endif

  always_comb begin
    load_d    = load_q;
    count_d   = count_q;
    en_d      = en_q;
    reload_d  = reload_q;
    ie_d      = ie_q;
    pend_d    = pend_q;
    rd_data_d = rd_data_q;

    if (ld_wr) load_d = bus.wr_data;

    if (ctrl_wr) begin
      en_d     = bus.wr_data[CTRL_EN_BIT];
      reload_d = bus.wr_data[CTRL_RELOAD_BIT];
      ie_d     = bus.wr_data[CTRL_IE_BIT];
    end

    // Enable load takes priority over a coincident tick. COUNT==0 ticks
    // fall through with no effect.
    if (en_edge) begin
      count_d = load_q;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (expire) begin
        if (reload_q) begin
          count_d = load_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end
    end

    // Set beats clear when both land on the same edge.
    if ((st_wr & bus.wr_data[STATUS_PEND_BIT]) | alert_ack) pend_d = 1'b0;
    if (expire) pend_d = 1'b1;

    if (rd_en) begin
      case (bus.addr)
        REG_LOAD:  rd_data_d = load_q;
        REG_COUNT: rd_data_d = count_q;
        REG_CTRL:  rd_data_d = ctrl_view;
        default: begin
          rd_data_d = '0;
          rd_data_d[STATUS_PEND_BIT] = pend_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q    <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      load_q    <= load_d;
      count_q   <= count_d;
      en_q      <= en_d;
      reload_q  <= reload_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign alert       = pend_q & ie_q;

endmodule

// File: tb/tb_interval_timer.sv
module tb_interval_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alert_ack = 1'b0;
  logic alert;
  int   tests = 0;
  int   fails = 0;

  interval_timer_if #(.WIDTH(32)) bus ();

  interval_timer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alert_ack (alert_ack),
    .alert     (alert)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each access lands on the next rising edge; returns 1ns after it.
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(posedge clk); #1;
    bus.sel = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wr_data = '0;

    // Reset state
    do_reset();
    chk("reset_alert", {31'd0, alert}, 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    rd_reg(2'd2, r); chk("reset_ctrl", r, 32'd0);

    // Periodic LOAD=5: alert at N+5, cleared, again at N+10
    wr_reg(2'd0, 32'd5);
    wr_reg(2'd2, 32'h7);                 // edge N
    cyc(4); chk("per5_before", {31'd0, alert}, 32'd0);
    cyc(1); chk("per5_rise", {31'd0, alert}, 32'd1);
    wr_reg(2'd3, 32'h1);                 // N+6
    chk("per5_cleared", {31'd0, alert}, 32'd0);
    cyc(3); chk("per5_before2", {31'd0, alert}, 32'd0);
    cyc(1); chk("per5_rise2", {31'd0, alert}, 32'd1);
    rd_reg(2'd1, r); chk("per5_count_reloaded", r, 32'd5);

    // One-shot LOAD=3
    do_reset();
    wr_reg(2'd0, 32'd3);
    wr_reg(2'd2, 32'h5);                 // edge N
    cyc(2); chk("os3_before", {31'd0, alert}, 32'd0);
    cyc(1); chk("os3_rise", {31'd0, alert}, 32'd1);
    rd_reg(2'd2, r); chk("os3_ctrl_en_cleared", r, 32'h4);
    rd_reg(2'd1, r); chk("os3_count_zero", r, 32'd0);
    rd_reg(2'd3, r); chk("os3_pend", r, 32'd1);
    wr_reg(2'd3, 32'h0);
    rd_reg(2'd3, r); chk("os3_w0_no_effect", r, 32'd1);

    // LOAD=0 enabled: never expires
    do_reset();
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd2, 32'h7);
    cyc(100); chk("load0_alert", {31'd0, alert}, 32'd0);
    rd_reg(2'd1, r); chk("load0_count", r, 32'd0);
    rd_reg(2'd3, r); chk("load0_pend", r, 32'd0);

    // Clear on expiry edge loses; ack one cycle later drops alert
    do_reset();
    wr_reg(2'd0, 32'd4);
    wr_reg(2'd2, 32'h7);                 // edge N
    repeat (3) @(posedge clk);           // at N+3
    wr_reg(2'd3, 32'h1);                 // N+4 = expiry
    chk("race_set_wins", {31'd0, alert}, 32'd1);
    @(negedge clk); alert_ack = 1'b1;
    @(posedge clk); #1; alert_ack = 1'b0; // N+5
    chk("ack_drops_alert", {31'd0, alert}, 32'd0);

    // IE=0 running: PEND set, no alert; then IE raises alert
    do_reset();
    wr_reg(2'd0, 32'd10);
    wr_reg(2'd2, 32'h3);                 // edge N
    cyc(10); chk("ie0_no_alert", {31'd0, alert}, 32'd0);
    rd_reg(2'd3, r); chk("ie0_pend", r, 32'd1);           // N+11
    wr_reg(2'd2, 32'h7);                                   // N+12, no reload
    chk("ie1_alert", {31'd0, alert}, 32'd1);
    rd_reg(2'd1, r); chk("rewrite_en_no_reload", r, 32'd8); // N+13
    wr_reg(2'd0, 32'd100);                                 // N+14
    rd_reg(2'd1, r); chk("load_wr_keeps_count", r, 32'd6); // N+15
    wr_reg(2'd1, 32'd55);                                  // N+16
    rd_reg(2'd1, r); chk("count_wr_ignored", r, 32'd4);    // N+17
    wr_reg(2'd2, 32'h6);                                   // N+18 disable, count 2
    cyc(5);
    rd_reg(2'd1, r); chk("disable_freezes", r, 32'd2);
    rd_reg(2'd3, r); chk("disable_keeps_pend", r, 32'd1);

`ifdef TIMER_PRESCALE_EN
    // PRESCALE=3, LOAD=2: alert 8 cycles after enable
    do_reset();
    wr_reg(2'd0, 32'd2);
    wr_reg(2'd2, 32'h307);               // edge N
    cyc(7); chk("presc_before", {31'd0, alert}, 32'd0);
    cyc(1); chk("presc_rise", {31'd0, alert}, 32'd1);
    rd_reg(2'd2, r); chk("presc_ctrl", r, 32'h307);
`else
    do_reset();
    wr_reg(2'd2, 32'h306);
    rd_reg(2'd2, r); chk("no_presc_ctrl", r, 32'h6);
`endif

    // Reset mid-count clears alert and rd_data at that edge
    do_reset();
    wr_reg(2'd0, 32'd2);
    wr_reg(2'd2, 32'h7);
    cyc(3); chk("prerst_alert", {31'd0, alert}, 32'd1);
    rd_reg(2'd0, r); chk("prerst_rd", r, 32'd2);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_alert", {31'd0, alert}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rst_n = 1'b1;
    rd_reg(2'd1, r); chk("rst_count", r, 32'd0);
    rd_reg(2'd0, r); chk("rst_load", r, 32'd0);
    rd_reg(2'd2, r); chk("rst_ctrl", r, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Memory-mapped down-counting timer that generates the `alert` interrupt level consumed by the CPU core's fetch stage. It is a slave on the memory controller's data-side register bus and supports one-shot and periodic modes with a sticky pending flag. `alert` stays asserted until software clears the pending flag or the core acknowledges the interrupt.

## Interface
- `WIDTH`, default 32: counter, LOAD and bus data width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `sel` input 1: register access strobe from the memory controller, one cycle per access.
- `wr` input 1: 1 = write, 0 = read; qualified by `sel`.
- `addr` input 2: word register index; 0 = LOAD, 1 = COUNT, 2 = CTRL, 3 = STATUS.
- `wr_data` input WIDTH: write data.
- `rd_data` output WIDTH: registered read data.
- `alert_ack` input 1: one-cycle pulse from the core when it takes the interrupt; clears PEND.
- `alert` output 1: interrupt request to the CPU, equal to PEND & IE.

## Operation
- Registers, all reset to 0:
  - LOAD: read/write.
  - COUNT: read-only; writes are ignored.
  - CTRL: bit 0 EN, bit 1 RELOAD (1 = periodic, 0 = one-shot), bit 2 IE, bits 15:8 PRESCALE (present only with the macro), other bits read 0.
  - STATUS: bit 0 PEND; writing 1 to bit 0 clears it, writing 0 has no effect.
- Enable edge: a CTRL write that takes EN from 0 to 1 loads COUNT with LOAD and clears the prescale counter. Rewriting EN=1 while EN is already 1 does not reload.
- Tick: every cycle while EN=1, or every PRESCALE+1 cycles when prescale is compiled in.
- On a tick with COUNT>1: COUNT decrements by 1.
- On a tick with COUNT==1 (expiry): PEND is set.
  - RELOAD=1: COUNT is reloaded with the current LOAD.
  - RELOAD=0: COUNT becomes 0 and EN is cleared by hardware.
- COUNT==0 with EN=1 (LOAD was 0): no tick effect and no expiry.
- Writing LOAD while running changes only the next reload or enable value; it does not change COUNT.
- EN cleared by software: COUNT freezes and PEND is kept.
- Simultaneous expiry and clear (STATUS write or `alert_ack`): the set wins and PEND stays 1.
- Simultaneous enable-edge write and tick: the enable load wins.
- `alert` is the AND of the PEND and IE flops, with no combinational path from any input.

## Timing
- Writes take effect at the edge where `sel & wr` is sampled.
- Reads: `rd_data` is valid the cycle after `sel & !wr` and returns register contents as they were before that edge. It holds its value until the next read. It is 0 after reset.
- With an enable write at edge N, LOAD=L≥1 and no prescale: COUNT=L after edge N, reaches 0 or reloads at edge N+L, and `alert` is high from edge N+L.
- Periodic period is exactly L ticks. With prescale P, the period is L·(P+1) cycles.
- `alert_ack` at edge M: `alert` is low after edge M unless an expiry occurs at M.
- Reset asserted mid-count: every register, `rd_data` and `alert` return to 0 at that edge.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - CTRL[15:8] PRESCALE is implemented and read/write.
  - An 8-bit prescale counter generates the tick.
- Not defined:
  - CTRL[15:8] reads 0 and ignores writes.
  - The tick occurs every cycle while EN=1.
  - No prescale logic is synthesized.

## Structure
- `timer_pkg` holds:
  - register index constants (LOAD/COUNT/CTRL/STATUS);
  - CTRL bit positions (EN, RELOAD, IE, PRESCALE field);
  - STATUS PEND bit position.
- Sub-module `timer_prescaler`: prescale counter plus tick output, instantiated only under `TIMER_PRESCALE_EN`.

## Test plan
- LOAD=5, CTRL=0x7 (EN, RELOAD, IE) at edge N: `alert` rises at edge N+5. Clearing STATUS then gives the next rise at edge N+10.
- LOAD=3, CTRL=0x5 (one-shot): PEND set at N+3. A CTRL read returns EN=0 and a COUNT read returns 0.
- LOAD=0, CTRL=0x7: COUNT stays 0 and `alert` stays 0 for 100 cycles.
- Periodic LOAD=4: a STATUS write-1 on the expiry edge leaves PEND=1. `alert_ack` one cycle later drops `alert`.
- Running LOAD=10, CTRL=0x3, IE=0: PEND is set but `alert` stays 0. Setting IE raises `alert` the next cycle.
- With `TIMER_PRESCALE_EN`, PRESCALE=3 and LOAD=2: `alert` rises 8 cycles after the enable edge. Mid-count `rst_n`=0 clears all outputs at that edge.
